acc_writeback: RTL and testbench
================================

Name: acc_writeback

Overview:
Drain side of the accumulator. Takes the accumulator value plus a destination code from the decoder and writes it to the register file and/or data memory. Register writes retire in one cycle. Memory writes are buffered in a small FIFO and issued over a req/ack handshake to a multi-cycle data memory. The block raises a stall to the fetch/decode stage when the FIFO cannot accept a new write.

Parameters:
DW, 8, data width (matches accumulator width)
RAW, 4, register file address width
MAW, 8, data memory address width
DEPTH, 2, memory write FIFO entries (power of two, >=2)

Ports:
CLK  input  1  clock
RESET_N  input  1  asynchronous active-low reset
wb_valid  input  1  writeback request this cycle
dest_ctrl  input  2  00 none, 01 reg, 10 mem, 11 reg+mem
acc_in  input  DW  accumulator output value
reg_addr_in  input  RAW  destination register
mem_addr_in  input  MAW  destination memory address
stall_out  output  1  FIFO full; upstream must hold wb_valid and its operands
reg_we  output  1  register file write enable
reg_waddr  output  RAW  register write address
reg_wdata  output  DW  register write data
mem_req  output  1  memory write request
mem_addr  output  MAW  memory write address
mem_wdata  output  DW  memory write data
mem_ack  input  1  one-cycle acknowledge from memory
busy  output  1  FIFO non-empty or mem_req high

Behaviour:
- Reset (async, RESET_N=0): reg_we=0, reg_waddr=0, reg_wdata=0, mem_req=0, mem_addr=0, mem_wdata=0, FIFO count=0, FSM=IDLE. stall_out=0, busy=0.
- Reset mid-transaction: mem_req drops immediately and pending FIFO entries are discarded. A late mem_ack after reset release while in IDLE is ignored.
- Accept condition: wb_valid && !stall_out. If wb_valid is high while stall_out is high, nothing is accepted. This includes the register half of dest_ctrl=11, so a write is never split.
- Register path: on accept with dest_ctrl[0]=1, reg_we=1 and reg_waddr/reg_wdata are loaded on the next CLK edge, giving 1-cycle latency. Otherwise reg_we=0 that cycle.
- Memory path: on accept with dest_ctrl[1]=1, push {mem_addr_in, acc_in} into the FIFO.
- stall_out = (count==DEPTH). It is registered-count based and does not consider a same-cycle pop.
- Simultaneous push and pop: allowed when not full. The count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- FSM IDLE:
  - If the FIFO is non-empty, load the head into mem_addr/mem_wdata, set mem_req=1, and go to REQ. The request appears on the cycle after the entry becomes visible.
- FSM REQ:
  - mem_req, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack, pop the head. If another entry remains (excluding a same-cycle push), load it and stay in REQ with mem_req=1, giving back-to-back issue. Otherwise mem_req=0 and go to IDLE.
- mem_ack while in IDLE: ignored.
- dest_ctrl=00 with wb_valid: accepted, no effect.
- Writes to memory complete in issue order.

Optional Feature:
ACC_WB_FORWARD_EN.
- Enabled, adds ports:
  - ld_addr input MAW.
  - fwd_hit output 1.
  - fwd_data output DW.
- Combinational search of valid FIFO entries (including the in-flight head) for ld_addr. The youngest matching entry wins. fwd_hit=1 and fwd_data= that entry's data; otherwise fwd_hit=0 and fwd_data=0.
- Disabled: the ports are absent and no compare logic is built.

Decomposition:
- Shared package (existing CPU package): typedef enum for dest_ctrl codes (DEST_NONE, DEST_REG, DEST_MEM, DEST_BOTH), widths DW/RAW/MAW, typedef struct wb_entry_t {addr, data}.
- One sub-module: wb_fifo. It is a parameterised synchronous FIFO of wb_entry_t with push, pop, head, full, empty and count, and exposes its entry array for the forwarding compare.
- The FSM and register path live in acc_writeback.

Test Plan:
- Register-only: wb_valid=1, dest=01, acc_in=8'h5A, reg_addr_in=3 -> next cycle reg_we=1, reg_waddr=3, reg_wdata=8'h5A; mem_req stays 0.
- Memory with 3-cycle ack: dest=10, acc_in=8'hC3, mem_addr_in=8'h40 -> mem_req=1 with addr 8'h40 and data 8'hC3 held for 3 cycles; drops the cycle after mem_ack; busy returns to 0.
- Both plus back-to-back: two dest=11 writes (8'h11 to 8'h10, then 8'h22 to 8'h11) with ack tied high -> two reg writes on consecutive cycles; mem_req continuous for two acks in order 8'h10 then 8'h11.
- Full/stall: mem_ack=0, issue 3 mem writes -> stall_out=1 after 2 accepts; third held (no reg write, no push) until the first ack; third then accepted; final order preserved.
- Reset mid-request: mem_req=1 with 2 entries, RESET_N=0 -> mem_req=0 immediately; after release, busy=0 and no request issues.
- ACC_WB_FORWARD_EN: pending writes 8'h40<-8'hAA then 8'h40<-8'hBB, ld_addr=8'h40 -> fwd_hit=1, fwd_data=8'hBB; ld_addr=8'h41 -> fwd_hit=0.

Source files
------------

// File: rtl/acc_writeback_pkg.sv
// Shared types for the accumulator writeback path: destination codes, widths and
// the buffered memory-write entry.
package acc_writeback_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned RAW      = 4;
  localparam int unsigned MAW      = 8;
  localparam int unsigned WB_DEPTH = 2;

  typedef enum logic [1:0] {
    DEST_NONE = 2'b00,
    DEST_REG  = 2'b01,
    DEST_MEM  = 2'b10,
    DEST_BOTH = 2'b11
  } dest_e;

  typedef struct packed {
    logic [MAW-1:0] addr;
    logic [DW-1:0]  data;
  } wb_entry_t;

  function automatic logic dest_has_reg(dest_e d);
    return (d == DEST_REG) || (d == DEST_BOTH);
  endfunction

  function automatic logic dest_has_mem(dest_e d);
    return (d == DEST_MEM) || (d == DEST_BOTH);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending memory writes; exposes its storage and read pointer
// so the owner can look ahead and search the queued entries.
module wb_fifo
  import acc_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_entry_t       din,
  input  logic            pop,
  output wb_entry_t       head,
  output wb_entry_t       entries [DEPTH],
  output logic [PW-1:0]   rd_ptr,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Full/empty are kept as flops alongside the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign entries = mem;
  assign head    = mem[rd_ptr];

endmodule

// File: rtl/acc_writeback.sv
// Accumulator writeback: one-cycle register writes plus FIFO-buffered memory writes
// issued over req/ack. Optional store-to-load forwarding under ACC_WB_FORWARD_EN.
module acc_writeback
  import acc_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            wb_valid,
  input  logic [1:0]      dest_ctrl,
  input  logic [DW-1:0]   acc_in,
  input  logic [RAW-1:0]  reg_addr_in,
  input  logic [MAW-1:0]  mem_addr_in,
  output logic            stall_out,
  output logic            reg_we,
  output logic [RAW-1:0]  reg_waddr,
  output logic [DW-1:0]   reg_wdata,
  output logic            mem_req,
  output logic [MAW-1:0]  mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
`ifdef ACC_WB_FORWARD_EN
  input  logic [MAW-1:0]  ld_addr,
  output logic            fwd_hit,
  output logic [DW-1:0]   fwd_data,
`endif
  output logic            busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e         state;
  dest_e          dest;
  logic           accept;
  logic           push;
  logic           pop;
  wb_entry_t      head;
  wb_entry_t      next_entry;
  wb_entry_t      entries [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  assign dest      = dest_e'(dest_ctrl);
  assign accept    = wb_valid && !full;
  assign push      = accept && dest_has_mem(dest);
  assign pop       = (state == REQ) && mem_ack;
  assign stall_out = full;
  assign busy      = !empty || mem_req;
  // Entry behind the head, used for back-to-back issue on ack.
  assign next_entry = entries[rd_ptr + PW'(1)];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .push    (push),
    .din     ({mem_addr_in, acc_in}),
    .pop     (pop),
    .head    (head),
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Register path and memory request FSM.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      reg_we <= accept && dest_has_reg(dest);
      if (accept && dest_has_reg(dest)) begin
        reg_waddr <= reg_addr_in;
        reg_wdata <= acc_in;
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            mem_addr  <= head.addr;
            mem_wdata <= head.data;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (count > CW'(1)) begin
              mem_addr  <= next_entry.addr;
              mem_wdata <= next_entry.data;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_WB_FORWARD_EN
  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (entries[rd_ptr + PW'(k)].addr == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[rd_ptr + PW'(k)].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acc_writeback.sv
// Bench for acc_writeback: directed scenarios with literal expectations, then random
// traffic checked each cycle against a queue-based reference model.
module tb_acc_writeback;

  localparam int unsigned DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       wb_valid = 1'b0;
  logic [1:0] dest_ctrl = 2'b00;
  logic [7:0] acc_in = '0;
  logic [3:0] reg_addr_in = '0;
  logic [7:0] mem_addr_in = '0;
  logic       mem_ack = 1'b0;
  logic       stall_out, reg_we, mem_req, busy;
  logic [3:0] reg_waddr;
  logic [7:0] reg_wdata, mem_addr, mem_wdata;
`ifdef ACC_WB_FORWARD_EN
  logic [7:0] ld_addr = '0;
  logic       fwd_hit;
  logic [7:0] fwd_data;
`endif

  int total = 0;
  int bad = 0;

  acc_writeback #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .wb_valid    (wb_valid),
    .dest_ctrl   (dest_ctrl),
    .acc_in      (acc_in),
    .reg_addr_in (reg_addr_in),
    .mem_addr_in (mem_addr_in),
    .stall_out   (stall_out),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
`ifdef ACC_WB_FORWARD_EN
    .ld_addr     (ld_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
`endif
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue of {addr,data}, plus the issued request.
  logic [15:0] q[$];
  logic        m_req = 1'b0;
  logic [7:0]  m_addr = '0, m_wdata = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_waddr = '0;
  logic [7:0]  m_wdata_r = '0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q.delete();
      m_req = 1'b0; m_addr = '0; m_wdata = '0;
      m_we = 1'b0; m_waddr = '0; m_wdata_r = '0;
    end else begin
      logic ok;
      ok = wb_valid && (q.size() != DEPTH);
      m_we = ok && dest_ctrl[0];
      if (m_we) begin
        m_waddr = reg_addr_in;
        m_wdata_r = acc_in;
      end
      if (m_req) begin
        if (mem_ack) begin
          void'(q.pop_front());
          if (q.size() > 0) begin
            m_addr = q[0][15:8]; m_wdata = q[0][7:0];
          end else begin
            m_req = 1'b0;
          end
        end
      end else if (q.size() > 0) begin
        m_req = 1'b1;
        m_addr = q[0][15:8]; m_wdata = q[0][7:0];
      end
      if (ok && dest_ctrl[1]) q.push_back({mem_addr_in, acc_in});
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge CLK) begin
    check("reg_we",    32'(reg_we),    32'(m_we));
    check("reg_waddr", 32'(reg_waddr), 32'(m_waddr));
    check("reg_wdata", 32'(reg_wdata), 32'(m_wdata_r));
    check("mem_req",   32'(mem_req),   32'(m_req));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("stall_out", 32'(stall_out), 32'(q.size() == DEPTH));
    check("busy",      32'(busy),      32'(q.size() > 0 || m_req));
`ifdef ACC_WB_FORWARD_EN
    begin
      logic h;
      logic [7:0] d;
      h = 1'b0; d = '0;
      for (int i = int'(q.size()) - 1; i >= 0; i--) begin
        if (!h && q[i][15:8] == ld_addr) begin
          h = 1'b1; d = q[i][7:0];
        end
      end
      check("fwd_hit",  32'(fwd_hit),  32'(h));
      check("fwd_data", 32'(fwd_data), 32'(d));
    end
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wr(input logic [1:0] d, input logic [7:0] a, input logic [3:0] r, input logic [7:0] m);
    wb_valid = 1'b1; dest_ctrl = d; acc_in = a; reg_addr_in = r; mem_addr_in = m;
  endtask

  initial begin
    tick(); tick();
    check("rst reg_we",   32'(reg_we),   32'd0);
    check("rst mem_req",  32'(mem_req),  32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst stall",    32'(stall_out), 32'd0);
    check("rst busy",     32'(busy),     32'd0);
    RESET_N = 1'b1;
    tick();

    // Register-only write.
    wr(2'b01, 8'h5A, 4'd3, 8'h00);
    tick(); wb_valid = 1'b0;
    check("reg only we",    32'(reg_we),    32'd1);
    check("reg only waddr", 32'(reg_waddr), 32'd3);
    check("reg only wdata", 32'(reg_wdata), 32'h5A);
    check("reg only req",   32'(mem_req),   32'd0);
    tick();
    check("reg only we off", 32'(reg_we), 32'd0);

    // Memory write with a 3-cycle ack.
    wr(2'b10, 8'hC3, 4'd0, 8'h40);
    tick(); wb_valid = 1'b0;
    check("mem busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mem hold req",  32'(mem_req),   32'd1);
      check("mem hold addr", 32'(mem_addr),  32'h40);
      check("mem hold data", 32'(mem_wdata), 32'hC3);
    end
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check("mem drop req", 32'(mem_req), 32'd0);
    check("mem idle busy", 32'(busy), 32'd0);

    // Both destinations, back-to-back, ack tied high.
    mem_ack = 1'b1;
    wr(2'b11, 8'h11, 4'd1, 8'h10);
    tick();
    check("b2b reg1", 32'(reg_waddr), 32'd1);
    wr(2'b11, 8'h22, 4'd2, 8'h11);
    tick(); wb_valid = 1'b0;
    check("b2b reg2 we",   32'(reg_we),    32'd1);
    check("b2b reg2 data", 32'(reg_wdata), 32'h22);
    check("b2b first addr", 32'(mem_addr), 32'h10);
    tick();
    check("b2b second req",  32'(mem_req),  32'd1);
    check("b2b second addr", 32'(mem_addr), 32'h11);
    tick(); mem_ack = 1'b0;
    check("b2b done req", 32'(mem_req), 32'd0);

    // Full / stall with held third write.
    wr(2'b10, 8'h01, 4'd0, 8'h20); tick();
    wr(2'b10, 8'h02, 4'd0, 8'h21); tick();
    check("full stall", 32'(stall_out), 32'd1);
    check("full head",  32'(mem_addr),  32'h20);
    wr(2'b11, 8'h03, 4'd5, 8'h22);
    tick();
    check("held no reg", 32'(reg_we), 32'd0);
    tick();
    check("held stall", 32'(stall_out), 32'd1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check("unstall",     32'(stall_out), 32'd0);
    check("second addr", 32'(mem_addr),  32'h21);
    check("still no reg", 32'(reg_we),   32'd0);
    tick(); wb_valid = 1'b0;
    check("third reg we",    32'(reg_we),    32'd1);
    check("third reg waddr", 32'(reg_waddr), 32'd5);
    mem_ack = 1'b1;
    tick();
    check("third addr", 32'(mem_addr),  32'h22);
    check("third data", 32'(mem_wdata), 32'h03);
    tick(); mem_ack = 1'b0;
    check("full drained", 32'(busy), 32'd0);

    // Reset in the middle of a request.
    wr(2'b10, 8'h44, 4'd0, 8'h50); tick();
    wr(2'b10, 8'h55, 4'd0, 8'h51); tick(); wb_valid = 1'b0;
    check("pre rst req", 32'(mem_req), 32'd1);
    #1 RESET_N = 1'b0;
    #1 check("rst now req", 32'(mem_req), 32'd0);
    check("rst now busy", 32'(busy), 32'd0);
    tick(); tick();
    RESET_N = 1'b1; mem_ack = 1'b1;
    tick(); tick(); mem_ack = 1'b0;
    check("post rst req",  32'(mem_req), 32'd0);
    check("post rst busy", 32'(busy),    32'd0);

`ifdef ACC_WB_FORWARD_EN
    wr(2'b10, 8'hAA, 4'd0, 8'h40); tick();
    wr(2'b10, 8'hBB, 4'd0, 8'h40); tick(); wb_valid = 1'b0;
    ld_addr = 8'h40;
    #1 check("fwd hit", 32'(fwd_hit), 32'd1);
    check("fwd young", 32'(fwd_data), 32'hBB);
    ld_addr = 8'h41;
    #1 check("fwd miss", 32'(fwd_hit), 32'd0);
    check("fwd miss data", 32'(fwd_data), 32'd0);
    mem_ack = 1'b1;
    tick(); tick(); tick(); mem_ack = 1'b0;
`endif

    // Random traffic; upstream honours stall by holding its request.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #1 RESET_N = 1'b0;
        wb_valid = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
      end
      if (!(stall_out && wb_valid)) begin
        wb_valid    = ($urandom % 3) != 0;
        dest_ctrl   = 2'($urandom);
        acc_in      = 8'($urandom);
        reg_addr_in = 4'($urandom);
        mem_addr_in = 8'($urandom_range(8'h37, 8'h30));
      end
      mem_ack = mem_req ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
`ifdef ACC_WB_FORWARD_EN
      ld_addr = 8'($urandom_range(8'h37, 8'h30));
`endif
      tick();
    end
    wb_valid = 1'b0; mem_ack = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
